// File: rtl/poly_accum_pkg.sv
`default_nettype none
// ============================================================================
// Module  : poly_accum_pkg
// Brief   : Shared types and constants for the odd-power term accumulator.
// Revision: 1.0 - initial release
// ============================================================================
package poly_accum_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Term i is weighted by 2^(i mod SHIFT_MOD) before accumulation
  localparam int SHIFT_MOD = 4;

endpackage : poly_accum_pkg
`default_nettype wire

// File: rtl/poly_lsb_find.sv
`default_nettype none
// ============================================================================
// Module  : poly_lsb_find
// Brief   : Combinational lowest-set-bit locator with an any-bit-set flag.
// Revision: 1.0 - initial release
// ============================================================================
module poly_lsb_find #(
  parameter int NUM_TERMS = 8,
  parameter int IDX_W     = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1
) (
  input  logic [NUM_TERMS-1:0] i_vec,
  output logic [IDX_W-1:0]     o_idx,
  output logic                 o_any
);

  // Walk from the top down so the last hit written is the lowest set index
  always_comb begin
    o_idx = '0;
    o_any = |i_vec;
    for (int i = NUM_TERMS - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx = IDX_W'(i);
      end
    end
  end

endmodule : poly_lsb_find
`default_nettype wire

// File: rtl/poly_accum.sv
`default_nettype none
// ============================================================================
// Module  : poly_accum
// Brief   : Sequential accumulator of mask-selected odd-power terms. One
//           selected term is added per cycle, lowest index first, each
//           weighted by 2^(index mod 4).
//           Optional feature macro POLY_ACCUM_PARITY_EN adds out_parity,
//           the XOR-reduction of out_data.
// Revision: 1.0 - initial release
// ============================================================================
module poly_accum
  import poly_accum_pkg::*;
#(
  parameter int NUM_TERMS  = 8,
  parameter int DATA_WIDTH = 21,
  parameter int OUT_WIDTH  = DATA_WIDTH + 3 + $clog2(NUM_TERMS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_vld,
  output logic                            in_rdy,
  input  logic [NUM_TERMS-1:0]            mask,
  input  logic [NUM_TERMS*DATA_WIDTH-1:0] terms,
  output logic                            out_vld,
  input  logic                            out_rdy,
  output logic [OUT_WIDTH-1:0]            out_data,
  output logic [$clog2(NUM_TERMS):0]      out_nterms
`ifdef POLY_ACCUM_PARITY_EN
  ,
  output logic                            out_parity
`endif
);

  localparam int IDX_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam int CNT_W = $clog2(NUM_TERMS) + 1;

  state_t                          r_state;
  logic [NUM_TERMS-1:0]            r_mask;
  logic [NUM_TERMS*DATA_WIDTH-1:0] r_terms;
  logic [OUT_WIDTH-1:0]            r_acc;
  logic [CNT_W-1:0]                r_cnt;
  logic                            r_in_rdy;
  logic                            r_out_vld;

  logic [IDX_W-1:0]                w_idx;
  logic                            w_any;
  logic [NUM_TERMS-1:0]            w_onehot;
  logic [NUM_TERMS-1:0]            w_mask_next;
  logic [DATA_WIDTH-1:0]           w_term;
  logic [31:0]                     w_shamt;
  logic [OUT_WIDTH-1:0]            w_addend;
  logic [OUT_WIDTH-1:0]            w_acc_next;

  poly_lsb_find #(
    .NUM_TERMS (NUM_TERMS),
    .IDX_W     (IDX_W)
  ) u_lsb_find (
    .i_vec (r_mask),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Select the lowest remaining term, weight it and form the next sum/mask
  always_comb begin
    w_onehot        = '0;
    w_onehot[w_idx] = 1'b1;
    w_mask_next     = r_mask & ~w_onehot;
    w_term          = r_terms[32'(w_idx) * DATA_WIDTH +: DATA_WIDTH];
    w_shamt         = 32'(w_idx) % SHIFT_MOD;
    w_addend        = OUT_WIDTH'(w_term) << w_shamt;
    w_acc_next      = r_acc + w_addend;
  end

  // Controller: capture request, add one term per cycle, hold result until taken
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_mask    <= '0;
      r_terms   <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_in_rdy  <= 1'b1;
      r_out_vld <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_vld) begin
            r_mask   <= mask;
            r_terms  <= terms;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_in_rdy <= 1'b0;
            if (mask == '0) begin
              r_state   <= DONE;
              r_out_vld <= 1'b1;
            end else begin
              r_state <= SCAN;
            end
          end
        end
        SCAN: begin
          if (w_any) begin
            r_acc  <= w_acc_next;
            r_mask <= w_mask_next;
            r_cnt  <= r_cnt + CNT_W'(1);
            if (w_mask_next == '0) begin
              r_state   <= DONE;
              r_out_vld <= 1'b1;
            end
          end else begin
            r_state   <= DONE;
            r_out_vld <= 1'b1;
          end
        end
        DONE: begin
          if (out_rdy) begin
            r_state   <= IDLE;
            r_out_vld <= 1'b0;
            r_in_rdy  <= 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_out_vld <= 1'b0;
          r_in_rdy  <= 1'b1;
        end
      endcase
    end
  end

`ifdef POLY_ACCUM_PARITY_EN
  logic r_parity;

  // Parity tracks the accumulator register so it is valid alongside out_data
  always_ff @(posedge clk) begin
    if (reset) begin
      r_parity <= 1'b0;
    end else if ((r_state == IDLE) && in_vld) begin
      r_parity <= 1'b0;
    end else if ((r_state == SCAN) && w_any) begin
      r_parity <= ^w_acc_next;
    end
  end

  assign out_parity = r_parity;
`endif

  assign in_rdy     = r_in_rdy;
  assign out_vld    = r_out_vld;
  assign out_data   = r_acc;
  assign out_nterms = r_cnt;

endmodule : poly_accum
`default_nettype wire

// File: tb/tb_poly_accum.sv
`default_nettype none
// ============================================================================
// Module  : tb_poly_accum
// Brief   : Directed self-checking bench for poly_accum (default parameters).
// Revision: 1.0 - initial release
// ============================================================================
module tb_poly_accum;

  localparam int NT = 8;
  localparam int DW = 21;
  localparam int OW = DW + 3 + 3;

  logic              clk;
  logic              reset;
  logic              in_vld;
  logic              in_rdy;
  logic [NT-1:0]     mask;
  logic [NT*DW-1:0]  terms;
  logic              out_vld;
  logic              out_rdy;
  logic [OW-1:0]     out_data;
  logic [3:0]        out_nterms;
`ifdef POLY_ACCUM_PARITY_EN
  logic              out_parity;
`endif

  int total = 0;
  int bad   = 0;
  logic [NT*DW-1:0] tv;

  poly_accum dut (
    .clk        (clk),
    .reset      (reset),
    .in_vld     (in_vld),
    .in_rdy     (in_rdy),
    .mask       (mask),
    .terms      (terms),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .out_data   (out_data),
    .out_nterms (out_nterms)
`ifdef POLY_ACCUM_PARITY_EN
    ,
    .out_parity (out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present a request at the current negedge; returns #1 after the accept edge
  task automatic send(input string tag, input logic [NT-1:0] m, input logic [NT*DW-1:0] t);
    in_vld = 1'b1;
    mask   = m;
    terms  = t;
    chk({tag, "_in_rdy"}, 64'(in_rdy), 64'd1);
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    mask   = 8'hFF;
    terms  = {(NT*DW){1'b1}};
  endtask

  // Count edges from accept until out_vld shows, bounded
  task automatic wait_out(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_vld && lat < 40);
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic check_out(input string tag, input logic [63:0] ed, input logic [63:0] en);
    chk({tag, "_out_vld"}, 64'(out_vld), 64'd1);
    chk({tag, "_data"}, 64'(out_data), ed);
    chk({tag, "_nterms"}, 64'(out_nterms), en);
  endtask

  task automatic handshake(input string tag);
    out_rdy = 1'b1;
    @(posedge clk);
    #1;
    out_rdy = 1'b0;
    @(negedge clk);
    chk({tag, "_vld_drop"}, 64'(out_vld), 64'd0);
    chk({tag, "_rdy_back"}, 64'(in_rdy), 64'd1);
  endtask

  initial begin
    reset   = 1'b1;
    in_vld  = 1'b0;
    out_rdy = 1'b0;
    mask    = '0;
    terms   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_nterms", 64'(out_nterms), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Empty mask: immediate zero result
    tv = {NT{21'h12345}};
    send("m00", 8'h00, tv);
    wait_out("m00", 1);
    check_out("m00", 64'd0, 64'd0);
    handshake("m00");

    // Single term, no weighting
    tv = {NT{21'h0AAAA}};
    tv[0*DW +: DW] = 21'd5;
    send("m01", 8'h01, tv);
    wait_out("m01", 2);
    check_out("m01", 64'd5, 64'd1);
    handshake("m01");

    // Weights 1,2,4,8 on unit terms
    tv = {NT{21'h1FFFFF}};
    for (int i = 0; i < 4; i++) tv[i*DW +: DW] = 21'd1;
    send("m0f", 8'h0F, tv);
    wait_out("m0f", 5);
    check_out("m0f", 64'd15, 64'd4);
    handshake("m0f");

    // Sparse mask, unselected terms must not contribute: 3<<2 + 10<<1 + 100<<3
    tv = {NT{21'd7}};
    tv[2*DW +: DW] = 21'd3;
    tv[5*DW +: DW] = 21'd10;
    tv[7*DW +: DW] = 21'd100;
    send("ma4", 8'hA4, tv);
    wait_out("ma4", 4);
    check_out("ma4", 64'd832, 64'd3);
    handshake("ma4");

    // All terms at maximum: (2^21-1)*30
    tv = {NT{21'h1FFFFF}};
    send("mff", 8'hFF, tv);
    wait_out("mff", 9);
    check_out("mff", 64'd62914530, 64'd8);
`ifdef POLY_ACCUM_PARITY_EN
    chk("mff_parity", 64'(out_parity), 64'd1);
`endif
    handshake("mff");

    // Back-pressure: result holds, requests ignored, input changes ignored
    tv = {NT{21'd0}};
    tv[0*DW +: DW] = 21'd9;
    send("hold", 8'h01, tv);
    wait_out("hold", 2);
    for (int k = 0; k < 5; k++) begin
      in_vld = 1'b1;
      mask   = 8'hFF;
      terms  = {NT{21'($urandom)}};
      @(negedge clk);
      check_out("hold", 64'd9, 64'd1);
      chk("hold_in_rdy", 64'(in_rdy), 64'd0);
    end
    in_vld = 1'b0;
    handshake("hold");

    // Reset in the middle of a scan discards the operation
    tv = {NT{21'd1}};
    send("rscan", 8'hF0, tv);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rscan_in_rdy", 64'(in_rdy), 64'd1);
    chk("rscan_out_vld", 64'(out_vld), 64'd0);
    chk("rscan_data", 64'(out_data), 64'd0);
    chk("rscan_nterms", 64'(out_nterms), 64'd0);
    repeat (4) @(negedge clk);
    chk("rscan_no_out", 64'(out_vld), 64'd0);

    // Post-reset request: term1=3 weighted by 2
    tv = {NT{21'd0}};
    tv[1*DW +: DW] = 21'd3;
    send("m02", 8'h02, tv);
    wait_out("m02", 2);
    check_out("m02", 64'd6, 64'd1);
    handshake("m02");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_poly_accum
`default_nettype wire
